// File: rtl/lcd_write_sequencer_pkg.sv
// Shared types, init command ROM and command classification for the
// HD44780 write sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        IDLE
    } lcd_state_e;

    localparam int LCD_INIT_LEN = 6;

    // Function set 8-bit/2-line (x3), display on, clear, entry mode increment.
    localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{
        8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
    };

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Valid/ready write-request channel into the LCD write sequencer.
interface lcd_req_if;
    logic       valid;
    logic       ready;
    logic       rs;
    logic [7:0] data;

    modport master (output valid, output rs, output data, input ready);
    modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_write_sequencer_timer.sv
// Load/count-down phase timer; done_o is high while the count sits at zero.
module lcd_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= value_i;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done_o = (r_cnt == '0);

endmodule

// File: rtl/lcd_write_sequencer.sv
// Drives the DE2 character LCD pins: runs the power-on init sequence, then
// turns each accepted command/data byte into a timed EN strobe.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int T_POWERON   = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CNT_W       = 20
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lcd_req_if.slave    req,
    input  logic        lcd_on_i,
    output logic        busy_o,
    output logic        init_done_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rw_o,
    output logic        lcd_rs_o,
    output logic        lcd_en_o,
    output logic        lcd_on_o
);

    if (T_POWERON < 3 || T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 1 ||
        T_EXEC < 2 || T_EXEC_LONG < 2) begin : g_bad_duration
        $error("lcd_write_sequencer: phase duration below its legal minimum");
    end
    if ((T_POWERON >> CNT_W) != 0 || (T_EXEC_LONG >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("lcd_write_sequencer: CNT_W too narrow for the longest wait");
    end

    // The arming cycle and the INIT_LOAD cycle fall inside the power-on budget.
    localparam logic [CNT_W-1:0] C_POWERON   = CNT_W'(T_POWERON - 3);
    localparam logic [CNT_W-1:0] C_SETUP     = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_PULSE     = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] C_HOLD      = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_EXEC      = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] C_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);
    // Mid-init the following INIT_LOAD cycle completes the execution wait.
    localparam logic [CNT_W-1:0] C_EXEC_I      = CNT_W'(T_EXEC - 2);
    localparam logic [CNT_W-1:0] C_EXEC_LONG_I = CNT_W'(T_EXEC_LONG - 2);
    localparam logic [2:0]       LAST_IDX      = 3'(LCD_INIT_LEN - 1);

    lcd_state_e       r_state;
    logic [2:0]       r_init_idx;
    logic             r_armed;
    logic             r_init_done;
    logic             r_ready;
    logic             r_busy;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_en;
    logic             r_on;

    logic             w_tmr_done;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_accept;
    logic             w_init_more;
    logic             w_long;

    assign w_accept    = r_ready && req.valid;
    assign w_init_more = !r_init_done && (r_init_idx != LAST_IDX);
    assign w_long      = is_long_cmd(r_rs, r_data);

    // Timer reload on every state entry, mirroring the transitions below.
    // NOTE: both outputs get a default first so no path through the case
    // leaves them unassigned and infers a latch.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            PWR_WAIT: begin
                w_tmr_load = !r_armed;
                w_tmr_val  = C_POWERON;
            end
            INIT_LOAD: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = C_SETUP;
            end
            SETUP: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = C_PULSE;
            end
            PULSE: begin
                w_tmr_load = w_tmr_done;
                w_tmr_val  = C_HOLD;
            end
            HOLD: begin
                w_tmr_load = w_tmr_done;
                if (w_init_more) w_tmr_val = w_long ? C_EXEC_LONG_I : C_EXEC_I;
                else             w_tmr_val = w_long ? C_EXEC_LONG   : C_EXEC;
            end
            IDLE: begin
                w_tmr_load = w_accept;
                w_tmr_val  = C_SETUP;
            end
            default: ;
        endcase
    end

    lcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_tmr_load),
        .value_i (w_tmr_val),
        .done_o  (w_tmr_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= PWR_WAIT;
            r_init_idx  <= '0;
            r_armed     <= 1'b0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_data      <= '0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_on        <= 1'b0;
        end else begin
            r_on <= lcd_on_i;
            case (r_state)
                PWR_WAIT: begin
                    if (!r_armed)        r_armed <= 1'b1;
                    else if (w_tmr_done) r_state <= INIT_LOAD;
                end
                INIT_LOAD: begin
                    r_rs    <= 1'b0;
                    r_data  <= LCD_INIT_SEQ[r_init_idx];
                    r_state <= SETUP;
                end
                SETUP: begin
                    if (w_tmr_done) r_state <= PULSE;
                end
                // EN trails the state by one cycle, giving T_SETUP+1 of setup.
                PULSE: begin
                    r_en <= 1'b1;
                    if (w_tmr_done) r_state <= HOLD;
                end
                HOLD: begin
                    r_en <= 1'b0;
                    if (w_tmr_done) r_state <= EXEC;
                end
                EXEC: begin
                    if (w_tmr_done) begin
                        if (w_init_more) begin
                            r_init_idx <= r_init_idx + 3'd1;
                            r_state    <= INIT_LOAD;
                        end else begin
                            r_init_done <= 1'b1;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_rs    <= req.rs;
                        r_data  <= req.data;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign req.ready   = r_ready;
    assign busy_o      = r_busy;
    assign init_done_o = r_init_done;
    assign lcd_data_o  = r_data;
    assign lcd_rs_o    = r_rs;
    assign lcd_en_o    = r_en;
    assign lcd_on_o    = r_on;
    assign lcd_rw_o    = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed + randomized bench for lcd_write_sequencer; EN pulses are captured
// by a pin monitor and compared with timings derived from the write rules.
module tb_lcd_write_sequencer;

    localparam int TP  = 100;
    localparam int TS  = 2;
    localparam int TPU = 12;
    localparam int TH  = 2;
    localparam int TE  = 20;
    localparam int TEL = 50;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
        int         width;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_on_i = 1'b0;
    logic       busy_o, init_done_o, lcd_rw_o, lcd_rs_o, lcd_en_o, lcd_on_o;
    logic [7:0] lcd_data_o;

    lcd_req_if req_if ();

    lcd_write_sequencer #(
        .T_POWERON(TP), .T_SETUP(TS), .T_PULSE(TPU), .T_HOLD(TH),
        .T_EXEC(TE), .T_EXEC_LONG(TEL), .CNT_W(20)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req         (req_if),
        .lcd_on_i    (lcd_on_i),
        .busy_o      (busy_o),
        .init_done_o (init_done_o),
        .lcd_data_o  (lcd_data_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_en_o    (lcd_en_o),
        .lcd_on_o    (lcd_on_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin monitor: records every EN pulse and counts bus changes while EN is
    // high or within the hold window after it falls.
    pulse_t     pulses[$];
    int         stab_err  = 0;
    int         hold_left = 0;
    logic       en_prev   = 1'b0;
    logic [7:0] cap_data;
    logic       cap_rs;

    always @(negedge clk) begin
        if (lcd_en_o && !en_prev) begin
            cap_data = lcd_data_o;
            cap_rs   = lcd_rs_o;
            pulses.push_back('{lcd_rs_o, lcd_data_o, cyc, -1});
        end else if (lcd_en_o) begin
            if (lcd_data_o !== cap_data || lcd_rs_o !== cap_rs) stab_err++;
        end else begin
            if (en_prev) begin
                pulses[pulses.size()-1].width = cyc - pulses[pulses.size()-1].rise;
                hold_left = TH;
            end
            if (hold_left > 0) begin
                if (!rst && (lcd_data_o !== cap_data || lcd_rs_o !== cap_rs)) stab_err++;
                hold_left--;
            end
        end
        en_prev = lcd_en_o;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Reference timing: setup + pulse + hold + execution wait for this byte.
    function automatic int write_cycles(input logic rs, input logic [7:0] d);
        int ex;
        ex = (!rs && d >= 8'h01 && d <= 8'h03) ? TEL : TE;
        return TS + TPU + TH + ex;
    endfunction

    task automatic wait_ready(input string tag, output int at);
        int t = 0;
        while (!req_if.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_seen"}, req_if.ready, 1);
        at = cyc;
    endtask

    // Presents one request while ready is high; returns the accept edge number.
    task automatic do_write(input string tag, input logic rs, input logic [7:0] d, output int acc);
        int dummy;
        wait_ready({tag, "_pre"}, dummy);
        req_if.valid = 1'b1;
        req_if.rs    = rs;
        req_if.data  = d;
        acc = cyc + 1;
        @(negedge clk);
        req_if.valid = 1'b0;
        check({tag, "_ready_drop"}, req_if.ready, 0);
    endtask

    task automatic write_and_check(input string tag, input logic rs, input logic [7:0] d);
        int acc, at, p0, k;
        p0 = pulses.size();
        do_write(tag, rs, d, acc);
        wait_ready(tag, at);
        check({tag, "_latency"}, at - acc, write_cycles(rs, d));
        check({tag, "_npulse"}, pulses.size() - p0, 1);
        if (pulses.size() > p0) begin
            k = p0;
            check({tag, "_en_rise"}, pulses[k].rise - acc, TS + 1);
            check({tag, "_en_width"}, pulses[k].width, TPU);
            check({tag, "_data"}, {23'd0, pulses[k].rs, pulses[k].data}, {23'd0, rs, d});
        end
        check({tag, "_bus_held"}, lcd_data_o, d);
    endtask

    task automatic reset_and_init(input string tag);
        int base, t, exp_rise, exp_done, p0, n;
        logic [7:0] rom [6];
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        rst = 1'b1;
        req_if.valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_en"}, lcd_en_o, 0);
        check({tag, "_rst_bus"}, {lcd_rs_o, lcd_rw_o, lcd_data_o}, 0);
        check({tag, "_rst_flags"}, {req_if.ready, busy_o, init_done_o, lcd_on_o}, 4'b0100);
        p0   = pulses.size();
        rst  = 1'b0;
        base = cyc;
        t = 0;
        while (!init_done_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        exp_done = TP;
        for (int i = 0; i < 6; i++) exp_done += write_cycles(1'b0, rom[i]);
        check({tag, "_init_done_cycle"}, cyc - base, exp_done);
        check({tag, "_init_ready"}, {req_if.ready, busy_o}, 2'b10);
        n = pulses.size() - p0;
        check({tag, "_init_npulse"}, n, 6);
        if (n > 0) check({tag, "_no_early_en"}, (pulses[p0].rise - base) >= TP, 1);
        exp_rise = TP + TS + 1;
        for (int i = 0; i < 6 && i < n; i++) begin
            check($sformatf("%s_init%0d_data", tag, i),
                  {23'd0, pulses[p0+i].rs, pulses[p0+i].data}, {24'd0, rom[i]});
            check($sformatf("%s_init%0d_rise", tag, i), pulses[p0+i].rise - base, exp_rise);
            check($sformatf("%s_init%0d_width", tag, i), pulses[p0+i].width, TPU);
            exp_rise += write_cycles(1'b0, rom[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2, acc, at, p0, t;
        logic       rs;
        logic [7:0] d;

        req_if.valid = 1'b0;
        req_if.rs    = 1'b0;
        req_if.data  = 8'h00;

        reset_and_init("por");

        lcd_on_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lcd_on_high", lcd_on_o, 1);
        lcd_on_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lcd_on_low", lcd_on_o, 0);

        write_and_check("data41", 1'b1, 8'h41);
        write_and_check("clear01", 1'b0, 8'h01);
        write_and_check("cmd04", 1'b0, 8'h04);
        write_and_check("home02", 1'b0, 8'h02);
        write_and_check("short00", 1'b0, 8'h00);
        write_and_check("data01", 1'b1, 8'h01);

        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(1, 3));
            end
            write_and_check($sformatf("rnd%0d", i), rs, d);
        end

        // Back-to-back: valid stays high, second byte waits for ready.
        wait_ready("b2b_pre", at);
        p0 = pulses.size();
        req_if.valid = 1'b1;
        req_if.rs    = 1'b1;
        req_if.data  = 8'h48;
        acc1 = cyc + 1;
        @(negedge clk);
        req_if.data = 8'h49;
        t = 0;
        while (!req_if.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("b2b_ready_back", req_if.ready, 1);
        acc2 = cyc + 1;
        @(negedge clk);
        req_if.valid = 1'b0;
        check("b2b_accept_gap", acc2 - acc1, write_cycles(1'b1, 8'h48) + 1);
        check("b2b_second_taken", req_if.ready, 0);
        wait_ready("b2b_end", at);
        check("b2b_npulse", pulses.size() - p0, 2);
        if (pulses.size() - p0 >= 2) begin
            check("b2b_first", pulses[p0].data, 8'h48);
            check("b2b_second", pulses[p0+1].data, 8'h49);
            check("b2b_rise_gap", pulses[p0+1].rise - pulses[p0].rise, write_cycles(1'b1, 8'h48) + 1);
        end

        // A request shown only during the execution wait must be dropped.
        p0 = pulses.size();
        do_write("busy", 1'b1, 8'h61, acc);
        repeat (20) @(negedge clk);
        req_if.valid = 1'b1;
        req_if.rs    = 1'b1;
        req_if.data  = 8'h55;
        repeat (5) @(negedge clk);
        check("busy_not_ready", {req_if.ready, busy_o}, 2'b01);
        req_if.valid = 1'b0;
        wait_ready("busy", at);
        check("busy_latency", at - acc, write_cycles(1'b1, 8'h61));
        repeat (60) @(negedge clk);
        check("busy_npulse", pulses.size() - p0, 1);
        if (pulses.size() > p0) check("busy_data", pulses[p0].data, 8'h61);

        // Reset with EN high: pins drop asynchronously, init reruns.
        do_write("rstp", 1'b1, 8'h7E, acc);
        t = 0;
        while (!lcd_en_o && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("rstp_en_high", lcd_en_o, 1);
        #1 rst = 1'b1;
        #1;
        check("rstp_async_en", lcd_en_o, 0);
        check("rstp_async_flags", {req_if.ready, busy_o, init_done_o, lcd_data_o}, {3'b010, 8'h00});
        reset_and_init("rst2");
        write_and_check("after_rst", 1'b1, 8'h5A);

        check("bus_stable_during_en", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Sits downstream of the processor's LCD I/O register and directly drives the DE2 HD44780-compatible character LCD pins.
- Takes one command or data byte per valid/ready handshake and generates compliant timing: RS/DATA setup, EN pulse width, hold, and the controller execution wait.
- Runs the power-on initialisation sequence itself, so software never bit-bangs EN timing.

Parameters:
- T_POWERON, 750000, cycles to wait after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/DATA are stable with EN low before EN rises.
- T_PULSE, 12, cycles EN is held high.
- T_HOLD, 2, cycles RS/DATA are held after EN falls.
- T_EXEC, 2000, execution wait for data writes and short commands (40 us).
- T_EXEC_LONG, 82000, execution wait for clear/home commands (1.64 ms).
- CNT_W, 20, timer width; must hold max(T_POWERON, T_EXEC_LONG).

Ports:
- clk_i  in  1  system clock (CLOCK_50)
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  write request valid
- req_ready_o  out  1  block can accept a request this cycle
- req_rs_i  in  1  0 = command, 1 = data
- req_data_i  in  8  byte to write
- lcd_on_i  in  1  backlight/power enable request
- busy_o  out  1  sequence, init or execution wait in progress
- init_done_o  out  1  power-on init has completed
- lcd_data_o  out  8  LCD_DATA
- lcd_rw_o  out  1  LCD_RW, always 0 (write only)
- lcd_rs_o  out  1  LCD_RS
- lcd_en_o  out  1  LCD_EN
- lcd_on_o  out  1  LCD_ON

Behaviour:
- Reset state (asynchronous): lcd_data_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_on_o=0, req_ready_o=0, busy_o=1, init_done_o=0, state=PWR_WAIT.
- All pin outputs are registered. lcd_on_o is lcd_on_i registered one cycle.
- States: PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE.
- PWR_WAIT: timer loaded with T_POWERON. Expiry goes to INIT_LOAD.
- INIT_LOAD: loads RS=0 and ROM[idx] into the pin registers, then goes to SETUP.
  - ROM sequence: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (idx 0..5).
- SETUP: lasts T_SETUP cycles with EN=0, then PULSE.
- PULSE: lasts T_PULSE cycles with EN=1, then HOLD.
- HOLD: lasts T_HOLD cycles with EN=0, then EXEC.
- EXEC: lasts T_EXEC_LONG cycles when RS=0 and data is 0x01, 0x02 or 0x03; otherwise T_EXEC cycles.
  - If in init and idx<5: idx++ and go to INIT_LOAD.
  - If in init and idx==5: set init_done_o=1 and go to IDLE.
  - Otherwise: go to IDLE.
- IDLE: req_ready_o=1 and busy_o=0.
  - Handshake fires when req_valid_i && req_ready_o at a rising edge.
  - On that edge, req_rs_i/req_data_i are captured into the pin registers, state goes to SETUP, and ready drops on the next cycle.
- Latency:
  - Accept edge to ready high again = T_SETUP+T_PULSE+T_HOLD+T_EXEC(_LONG) cycles.
  - Cycles after the accept edge: EN rises at T_SETUP+1 and falls at T_SETUP+T_PULSE+1.
- req_ready_o is 0 in every state except IDLE. Requests presented while not ready are ignored, not queued; the requester holds valid.
- lcd_data_o and lcd_rs_o change only on accept or INIT_LOAD. They never change while EN=1 or during HOLD.
- Reset mid-sequence (including EN=1): EN drops immediately and the full init sequence restarts; any in-flight request is lost.
- Timer: a down-counter loaded on each state entry with (duration-1), with done at 0. A duration of 0 is illegal and is caught by a parameter assertion.
- A valid request with RS=0 and data 0x00 is a short command.

Decomposition:
- lcd_pkg:
  - state enum lcd_state_e
  - init ROM constant array LCD_INIT_SEQ[6] and its length
  - function is_long_cmd(rs, data)
- Sub-module lcd_timer:
  - CNT_W-wide load/count-down with done_o
  - asynchronous active-high reset to 0
  - instanced once

Test Plan (bench parameters: T_POWERON=100, T_SETUP=2, T_PULSE=12, T_HOLD=2, T_EXEC=20, T_EXEC_LONG=50):
- Power-on: deassert rst_i -> six EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0. init_done_o and req_ready_o rise at cycle 100+5*36+66=346. No EN pulse occurs before cycle 100.
- Data write: after init, valid with RS=1, data=0x41 -> accept, EN high for exactly 12 cycles starting 3 cycles after accept, DATA=0x41 stable from accept through HOLD, ready back after 36 cycles.
- Long command: RS=0, data=0x01 -> ready returns 66 cycles after accept. Then RS=0, data=0x04 -> 36 cycles.
- Back-to-back with valid held high: writes 0x48 then 0x49 -> second accepted exactly on the cycle ready reasserts; the data bus never changes while EN=1.
- Ignore while busy: pulse valid with data 0x55 during EXEC and drop it before IDLE -> no EN pulse for 0x55.
- Reset during PULSE: assert rst_i with EN=1 -> EN=0 in the same cycle (asynchronous), all outputs at reset values, init restarts and completes 346 cycles after release.
